// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port.
// The arbiter takes the master view; requesters and memory together take the slave view.
interface mem_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req_read;
   logic [N_REQ-1:0]        req_write;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]       req_rdata;
   logic                    mem_read;
   logic                    mem_write;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic                    mem_ready;
   logic [DATA_W-1:0]       mem_rdata;
   logic [ID_W-1:0]         grant_id;
   logic                    busy;

   modport master (
      input  req_read, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
      output req_ready, req_rdata, mem_read, mem_write, mem_addr, mem_wdata,
             grant_id, busy
   );

   modport slave (
      output req_read, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
      input  req_ready, req_rdata, mem_read, mem_write, mem_addr, mem_wdata,
             grant_id, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N_REQ requesters.
// One transaction at a time: IDLE (arbitrate) -> BUSY (strobe held) -> DONE (ready pulse).
module mem_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.master bus
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [ID_W-1:0]  rr;
   logic [ID_W-1:0]  win;
   logic [ID_W-1:0]  rr_next;
   logic             any_req;
   logic [N_REQ-1:0] pending;

   // Scan downward so the last hit is the nearest requester at or above rr.
   always_comb begin
      pending = bus.req_read | bus.req_write;
      any_req = 1'b0;
      win     = rr;
      rr_next = rr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (pending[(int'(rr) + k) % N_REQ]) begin
            any_req = 1'b1;
            win     = ID_W'((int'(rr) + k) % N_REQ);
            rr_next = ID_W'((int'(rr) + k + 1) % N_REQ);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         rr            <= '0;
         bus.grant_id  <= '0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.req_ready <= '0;
         bus.req_rdata <= '0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state         <= BUSY;
                  bus.busy      <= 1'b1;
                  bus.grant_id  <= win;
                  rr            <= rr_next;
                  bus.mem_addr  <= bus.req_addr[win*ADDR_W +: ADDR_W];
                  bus.mem_wdata <= bus.req_wdata[win*DATA_W +: DATA_W];
                  // A simultaneous read and write from one requester is served as a write.
                  bus.mem_write <= bus.req_write[win];
                  bus.mem_read  <= ~bus.req_write[win];
               end
            end
            BUSY: begin
               if (bus.mem_ready) begin
                  state         <= DONE;
                  bus.mem_read  <= 1'b0;
                  bus.mem_write <= 1'b0;
                  bus.req_ready <= N_REQ'(1) << bus.grant_id;
                  if (bus.mem_read) begin
                     bus.req_rdata <= bus.mem_rdata;
                  end
               end
            end
            DONE: begin
               // Requester drops its request here, so IDLE never sees it stale.
               state         <= IDLE;
               bus.busy      <= 1'b0;
               bus.req_ready <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of SM-core requesters sharing one memory port.
REQ-002 Parameter ADDR_W, default 16: memory address width.
REQ-003 Parameter DATA_W, default 32: memory data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_read  input  N_REQ  per-requester read request, level, held until req_ready.
REQ-007 req_write  input  N_REQ  per-requester write request, level, held until req_ready.
REQ-008 req_addr  input  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  input  N_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
REQ-010 req_ready  output  N_REQ  one-cycle completion pulse to the served requester.
REQ-011 req_rdata  output  DATA_W  read data, valid in the cycle req_ready is high for a read.
REQ-012 mem_read  output  1  read strobe to memory, held until mem_ready.
REQ-013 mem_write  output  1  write strobe to memory, held until mem_ready.
REQ-014 mem_addr  output  ADDR_W  latched address of the granted request.
REQ-015 mem_wdata  output  DATA_W  latched write data of the granted request.
REQ-016 mem_ready  input  1  memory completion, sampled only while BUSY.
REQ-017 mem_rdata  input  DATA_W  memory read data, sampled with mem_ready.
REQ-018 grant_id  output  $clog2(N_REQ)  index of the current/last granted requester.
REQ-019 busy  output  1  high in BUSY and DONE states.

Function
REQ-020 FSM states IDLE, BUSY, DONE; IDLE->BUSY when any req_read|req_write bit is set; BUSY->DONE on an edge sampling mem_ready=1; DONE->IDLE unconditionally.
REQ-021 Arbitration in IDLE only: round-robin search from pointer rr upward modulo N_REQ; first requester with read or write set wins.
REQ-022 On grant to g: latch grant_id=g, mem_addr, mem_wdata, op; rr <= (g+1) mod N_REQ.
REQ-023 If both req_read[g] and req_write[g] are set, write wins; read is not performed.
REQ-024 mem_read/mem_write are registered, high for the whole BUSY state per latched op, low in IDLE/DONE.
REQ-025 On the BUSY edge sampling mem_ready=1: req_ready[g] <= 1 for exactly the DONE cycle; for reads req_rdata <= mem_rdata.
REQ-026 req_rdata holds its value until the next read completion; writes never modify it.
REQ-027 Minimum transaction: request seen at edge 0, strobe high cycle 1, mem_ready in cycle 1, req_ready in cycle 2, IDLE in cycle 3 (3 cycles per transaction).
REQ-028 Requesters drop their request in the req_ready cycle; DONE guarantees no re-arbitration sees the stale request.
REQ-029 Request changes or drops during BUSY are ignored; latched transaction completes and req_ready still pulses.
REQ-030 mem_ready in IDLE or DONE is ignored; no req_ready generated.
REQ-031 mem_ready may be held low indefinitely; no timeout, strobes stay asserted.
REQ-032 At most one req_ready bit is high in any cycle.

Reset
REQ-033 reset=1 forces immediately (asynchronously) state=IDLE, rr=0, grant_id=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, req_ready=0, req_rdata=0, busy=0.
REQ-034 Reset during BUSY aborts the transaction: no req_ready issued; requester reissues after release.

Verification
REQ-035 Single read: req_read=4'b0100, req_addr[2]=0x0040, mem_ready 2 cycles after mem_read, mem_rdata=0xDEADBEEF -> mem_addr=0x0040, grant_id=2, req_ready=4'b0100 one cycle, req_rdata=0xDEADBEEF.
REQ-036 Fairness: all four requesting, re-asserting after each ready, mem_ready tied 1 -> grant order 0,1,2,3,0, one req_ready every 3 cycles.
REQ-037 Pointer wrap: rr=2 (after grant to 1), requests 4'b1010 -> grant 3 first, then 1.
REQ-038 Write: req_write[0], addr 0x1234, wdata 0xA5A5A5A5 -> mem_write=1, mem_read=0, mem_addr=0x1234, mem_wdata=0xA5A5A5A5; req_rdata unchanged.
REQ-039 Reset while BUSY with mem_ready low -> mem_read drops same cycle, no req_ready; after release, request from requesters 0 and 1 grants 0 first.
REQ-040 mem_ready pulsed in IDLE -> no req_ready; requester dropping request mid-BUSY -> req_ready still pulses on completion.
